// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: four-stage signed DSP slice (pre-adder, multiplier,
// post-adder/accumulator) with per-sample operation select.
//   opmode 00: P = (D+A)*B + C     01: P = (D-A)*B + C
//          10: P = P + (D+A)*B     11: P = C - (D-A)*B
// Optional feature macro: DSP_SAT_EN -- saturating post-adder with a sticky
// overflow flag. Without it the post-adder wraps and ovf is tied low.
module dsp_mac_pipe #(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int P_W = 48
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [1:0]            opmode,
  input  logic signed [A_W-1:0] A,
  input  logic signed [A_W-1:0] D,
  input  logic signed [B_W-1:0] B,
  input  logic signed [P_W-1:0] C,
  output logic                  out_valid,
  output logic signed [P_W-1:0] P,
  output logic                  ovf
);

  localparam int PRE_W = A_W + 1;
  localparam int M_W   = A_W + 1 + B_W;
`ifdef DSP_SAT_EN
  // One guard bit so the post-adder result can be range-checked before clamping.
  localparam int S_W   = P_W + 1;
`else
  localparam int S_W   = P_W;
`endif

  // Stage 1: input capture
  logic                  r_v1;
  logic [1:0]            r_op1;
  logic signed [A_W-1:0] r_a1;
  logic signed [A_W-1:0] r_d1;
  logic signed [B_W-1:0] r_b1;
  logic signed [P_W-1:0] r_c1;
  // Stage 2: pre-adder result
  logic                  r_v2;
  logic [1:0]            r_op2;
  logic signed [PRE_W-1:0] r_pre2;
  logic signed [B_W-1:0] r_b2;
  logic signed [P_W-1:0] r_c2;
  // Stage 3: product
  logic                  r_v3;
  logic [1:0]            r_op3;
  logic signed [M_W-1:0] r_m3;
  logic signed [P_W-1:0] r_c3;
  // Stage 4: result
  logic                  r_out_v;
  logic signed [P_W-1:0] r_p;

  logic signed [PRE_W-1:0] w_a_ext;
  logic signed [PRE_W-1:0] w_d_ext;
  logic signed [PRE_W-1:0] w_pre;
  logic signed [M_W-1:0]   w_m;
  logic signed [S_W-1:0]   w_p_ext;
  logic signed [S_W-1:0]   w_c_ext;
  logic signed [S_W-1:0]   w_m_ext;
  logic signed [S_W-1:0]   w_sum;
  logic signed [P_W-1:0]   w_res;

  assign w_a_ext = PRE_W'(r_a1);
  assign w_d_ext = PRE_W'(r_d1);
  assign w_pre   = r_op1[0] ? (w_d_ext - w_a_ext) : (w_d_ext + w_a_ext);
  assign w_m     = M_W'(r_pre2) * M_W'(r_b2);
  assign w_p_ext = S_W'(r_p);
  assign w_c_ext = S_W'(r_c3);
  assign w_m_ext = S_W'(r_m3);

  // Stage 1: capture operands and opmode only for valid samples.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_v1  <= 1'b0;
      r_op1 <= 2'b00;
      r_a1  <= '0;
      r_d1  <= '0;
      r_b1  <= '0;
      r_c1  <= '0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_op1 <= opmode;
        r_a1  <= A;
        r_d1  <= D;
        r_b1  <= B;
        r_c1  <= C;
      end
    end
  end

  // Stage 2: register the pre-adder sum/difference.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_v2   <= 1'b0;
      r_op2  <= 2'b00;
      r_pre2 <= '0;
      r_b2   <= '0;
      r_c2   <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_op2  <= r_op1;
        r_pre2 <= w_pre;
        r_b2   <= r_b1;
        r_c2   <= r_c1;
      end
    end
  end

  // Stage 3: register the full-precision product.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_v3  <= 1'b0;
      r_op3 <= 2'b00;
      r_m3  <= '0;
      r_c3  <= '0;
    end else begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_op3 <= r_op2;
        r_m3  <= w_m;
        r_c3  <= r_c2;
      end
    end
  end

  // Post-adder operation select; accumulate reads the live P register.
  always_comb begin
    w_sum = w_c_ext + w_m_ext;
    case (r_op3)
      2'b00:   w_sum = w_c_ext + w_m_ext;
      2'b01:   w_sum = w_c_ext + w_m_ext;
      2'b10:   w_sum = w_p_ext + w_m_ext;
      2'b11:   w_sum = w_c_ext - w_m_ext;
      default: w_sum = w_c_ext + w_m_ext;
    endcase
  end

`ifdef DSP_SAT_EN
  logic w_ovf;
  logic r_ovf;

  assign w_ovf = (w_sum[S_W-1] != w_sum[S_W-2]);

  // Clamp to the signed P range when the guard bit disagrees with the sign.
  always_comb begin
    w_res = w_sum[P_W-1:0];
    if (w_ovf) begin
      if (w_sum[S_W-1]) begin
        w_res = {1'b1, {(P_W-1){1'b0}}};
      end else begin
        w_res = {1'b0, {(P_W-1){1'b1}}};
      end
    end else begin
      w_res = w_sum[P_W-1:0];
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (r_v3 && w_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign w_res = w_sum;
  assign ovf   = 1'b0;
`endif

  // Stage 4: P updates only on valid results; out_valid pulses with each update.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_v <= 1'b0;
      r_p     <= '0;
    end else begin
      r_out_v <= r_v3;
      if (r_v3) begin
        r_p <= w_res;
      end
    end
  end

  assign out_valid = r_out_v;
  assign P         = r_p;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Testbench for dsp_mac_pipe: directed cases then randomized traffic, checked
// every cycle against an arithmetic reference model of the slice.
module tb_dsp_mac_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstn;
  logic                in_valid;
  logic [1:0]          opmode;
  logic signed [17:0]  A;
  logic signed [17:0]  D;
  logic signed [17:0]  B;
  logic signed [47:0]  C;
  logic                out_valid;
  logic signed [47:0]  P;
  logic                ovf;

  dsp_mac_pipe #(.A_W(18), .B_W(18), .P_W(48)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .opmode(opmode),
    .A(A), .D(D), .B(B), .C(C),
    .out_valid(out_valid), .P(P), .ovf(ovf)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Pending results: cycle they must appear, value, sticky ovf after them.
  int     q_due[$];
  longint q_val[$];
  bit     q_ovf[$];

  longint model_p   = 0;
  bit     model_ovf = 1'b0;
  longint shown_p   = 0;
  bit     shown_ovf = 1'b0;

  localparam longint PMAX = (longint'(1) <<< 47) - longint'(1);
  localparam longint PMIN = -(longint'(1) <<< 47);

  // Bring an exact result into the 48-bit P range (clamp or wrap).
  function automatic longint fit(input longint r, output bit ov);
    ov = 1'b0;
`ifdef DSP_SAT_EN
    if (r > PMAX) begin
      ov = 1'b1;
      return PMAX;
    end
    if (r < PMIN) begin
      ov = 1'b1;
      return PMIN;
    end
    return r;
`else
    return {{16{r[47]}}, r[47:0]};
`endif
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the clock, and check all outputs.
  task automatic step(input bit rst_n, input bit v, input logic [1:0] op,
                      input logic signed [17:0] a, input logic signed [17:0] d,
                      input logic signed [17:0] b, input logic signed [47:0] c);
    longint la, ld, lb, lc, pre, m, r;
    bit     ov;
    bit     exp_v;
    rstn = rst_n; in_valid = v; opmode = op; A = a; D = d; B = b; C = c;
    if (!rst_n) begin
      q_due.delete(); q_val.delete(); q_ovf.delete();
      model_p = 0; model_ovf = 1'b0;
    end else if (v) begin
      la = a; ld = d; lb = b; lc = c;
      pre = op[0] ? (ld - la) : (ld + la);
      m = pre * lb;
      case (op)
        2'b10:   r = model_p + m;
        2'b11:   r = lc - m;
        default: r = lc + m;
      endcase
      model_p = fit(r, ov);
      model_ovf = model_ovf | ov;
      q_due.push_back(cyc + 4);
      q_val.push_back(model_p);
      q_ovf.push_back(model_ovf);
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      shown_p = 0; shown_ovf = 1'b0;
    end
    #1;
    exp_v = 1'b0;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      exp_v = 1'b1;
      void'(q_due.pop_front());
      shown_p = q_val.pop_front();
      shown_ovf = q_ovf.pop_front();
    end
    chk("out_valid", {47'd0, out_valid}, {47'd0, exp_v});
    chk("P", P, shown_p[47:0]);
    chk("ovf", {47'd0, ovf}, {47'd0, shown_ovf});
  endtask

  task automatic idle(input bit rst_n);
    step(rst_n, 1'b0, 2'b00, 18'sd0, 18'sd0, 18'sd0, 48'sd0);
  endtask

  initial begin
    logic [63:0] rnd64;
    logic signed [17:0] ra, rd, rb;
    logic signed [47:0] rc;
    rstn = 1'b0; in_valid = 1'b0; opmode = 2'b00;
    A = '0; D = '0; B = '0; C = '0;

    // Reset state
    idle(1'b0);
    idle(1'b0);

    // Test 1: (19+15)*17+38 = 616, four cycles after issue
    step(1'b1, 1'b1, 2'b00, 18'sd15, 18'sd19, 18'sd17, 48'sd38);
    repeat (3) idle(1'b1);
    chk("t1_616", P, 48'd616);
    idle(1'b1);

    // Test 2: (19-15)*17+38 = 106; then C-(D-A)*B = 100-(3-2)*4
    step(1'b1, 1'b1, 2'b01, 18'sd15, 18'sd19, 18'sd17, 48'sd38);
    repeat (3) idle(1'b1);
    chk("t2_106", P, 48'd106);
    step(1'b1, 1'b1, 2'b11, 18'sd2, 18'sd3, 18'sd4, 48'sd100);
    repeat (4) idle(1'b1);

    // Test 3: back-to-back accumulates after reset -> 10, 20, 30
    idle(1'b0);
    repeat (3) step(1'b1, 1'b1, 2'b10, 18'sd1, 18'sd1, 18'sd5, 48'sd999);
    idle(1'b1);
    chk("t3_10", P, 48'd10);
    idle(1'b1);
    chk("t3_20", P, 48'd20);
    idle(1'b1);
    chk("t3_30", P, 48'd30);

    // Test 4: valid pattern 1,0,1,1; P must hold through the gap
    step(1'b1, 1'b1, 2'b00, 18'sd3,  18'sd4,  18'sd5,  48'sd7);
    idle(1'b1);
    step(1'b1, 1'b1, 2'b01, -18'sd9, 18'sd2,  -18'sd6, 48'sd11);
    step(1'b1, 1'b1, 2'b10, 18'sd8,  -18'sd1, 18'sd3,  48'sd0);
    repeat (5) idle(1'b1);

    // Test 5: reset with two samples in flight; nothing may emerge
    step(1'b1, 1'b1, 2'b00, 18'sd100, 18'sd200, 18'sd3, 48'sd5);
    step(1'b1, 1'b1, 2'b10, 18'sd50,  18'sd60,  18'sd7, 48'sd0);
    idle(1'b0);
    repeat (6) idle(1'b1);

    // Test 6: overflow of C by one
    step(1'b1, 1'b1, 2'b00, 18'sd1, 18'sd0, 18'sd1, 48'sh7FFF_FFFF_FFFF);
    repeat (3) idle(1'b1);
`ifdef DSP_SAT_EN
    chk("t6_sat_p", P, 48'h7FFF_FFFF_FFFF);
    chk("t6_sat_ovf", {47'd0, ovf}, 48'd1);
`else
    chk("t6_wrap_p", P, 48'h8000_0000_0000);
    chk("t6_wrap_ovf", {47'd0, ovf}, 48'd0);
`endif
    idle(1'b1);
    idle(1'b0);

    // Randomized mixed traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rnd64 = {$urandom, $urandom};
      ra = rnd64[17:0];
      rd = rnd64[35:18];
      rb = rnd64[53:36];
      rnd64 = {$urandom, $urandom};
      rc = rnd64[47:0];
      if ($urandom_range(0, 3) == 0) begin
        rc = {{8{rnd64[47]}}, rnd64[39:0]};
      end
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), ra, rd, rb, rc);
    end
    repeat (5) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
